// File: rtl/mic_window_reader.sv
// Consumer side of the microphone sample window. It edge-detects the divided
// sampling clock, snapshots the window every HOP ticks and streams it oldest-first.
module mic_window_reader #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 18,
  parameter int HOP   = 16
) (
  input  logic                     clk_25,
  input  logic                     reset_n,
  input  logic                     clk_sampling,
  input  logic [WIDTH-1:0]         samples [0:DEPTH-1],
  input  logic                     enable,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH)-1:0] out_index,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done,
  output logic                     overrun,
  output logic [7:0]               overrun_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [7:0]    HOP_LAST = 8'(HOP - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state;
  state_t           state_next;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             tick;
  logic             due;
  logic             beat_hs;
  logic             last_hs;
  logic             load_snap;
  logic [7:0]       hop_cnt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] snap [0:DEPTH-1];

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_sampling;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      hop_cnt <= 8'd0;
    end else if (tick && enable) begin
      hop_cnt <= (hop_cnt == HOP_LAST) ? 8'd0 : hop_cnt + 8'd1;
    end
  end

  assign due     = tick & enable & (hop_cnt == HOP_LAST);
  assign beat_hs = (state == STREAM) & out_ready;
  assign last_hs = beat_hs & (idx == LAST_IDX);

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A due tick landing on the last handshake reloads without an idle gap.
  always_comb begin
    state_next = state;
    load_snap  = 1'b0;
    case (state)
      IDLE: begin
        if (due) begin
          state_next = STREAM;
          load_snap  = 1'b1;
        end
      end
      STREAM: begin
        if (last_hs) begin
          if (due) begin
            load_snap = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (!reset_n) begin
      idx           <= '0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        snap[i] <= '0;
      end
    end else begin
      frame_done <= last_hs;
      overrun    <= due & (state == STREAM) & ~last_hs;
      if (due && (state == STREAM) && !last_hs && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (load_snap) begin
        snap <= samples;
        idx  <= '0;
      end else if (last_hs) begin
        idx <= '0;
      end else if (beat_hs) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Index 0 of the window is newest, so beat 0 reads the far end.
  assign rd_idx    = LAST_IDX - idx;
  assign out_valid = (state == STREAM);
  assign out_data  = out_valid ? snap[rd_idx] : '0;
  assign out_index = idx;
  assign out_first = out_valid & (idx == '0);
  assign out_last  = out_valid & (idx == LAST_IDX);

endmodule

// File: tb/tb_mic_window_reader.sv
// Directed bench for mic_window_reader: one HOP=16 instance and one HOP=1
// instance share the sampling clock, window and enable.
module tb_mic_window_reader;

  logic        clk_25 = 1'b0;
  logic        reset_n;
  logic        clk_sampling;
  logic        enable;
  logic [17:0] samples [0:15];

  logic [17:0] d16_data;
  logic [3:0]  d16_index;
  logic        d16_first, d16_last, d16_valid, d16_ready, d16_done, d16_ovr;
  logic [7:0]  d16_ovr_cnt;

  logic [17:0] d1_data;
  logic [3:0]  d1_index;
  logic        d1_first, d1_last, d1_valid, d1_ready, d1_done, d1_ovr;
  logic [7:0]  d1_ovr_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_25 = ~clk_25;

  mic_window_reader #(.DEPTH(16), .WIDTH(18), .HOP(16)) dut16 (
    .clk_25(clk_25), .reset_n(reset_n), .clk_sampling(clk_sampling),
    .samples(samples), .enable(enable),
    .out_data(d16_data), .out_index(d16_index), .out_first(d16_first),
    .out_last(d16_last), .out_valid(d16_valid), .out_ready(d16_ready),
    .frame_done(d16_done), .overrun(d16_ovr), .overrun_count(d16_ovr_cnt)
  );

  mic_window_reader #(.DEPTH(16), .WIDTH(18), .HOP(1)) dut1 (
    .clk_25(clk_25), .reset_n(reset_n), .clk_sampling(clk_sampling),
    .samples(samples), .enable(enable),
    .out_data(d1_data), .out_index(d1_index), .out_first(d1_first),
    .out_last(d1_last), .out_valid(d1_valid), .out_ready(d1_ready),
    .frame_done(d1_done), .overrun(d1_ovr), .overrun_count(d1_ovr_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) begin
      @(posedge clk_25);
      #1;
    end
  endtask

  // Each sampling-clock period here is 3 cycles high, 3 cycles low.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      clk_sampling = 1'b1;
      step_cycles(3);
      clk_sampling = 1'b0;
      step_cycles(3);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) samples[i] = 18'(i * 64);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step_cycles(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    clk_sampling = 1'b0;
    enable       = 1'b1;
    d16_ready    = 1'b1;
    d1_ready     = 1'b1;
    load_ramp();
    step_cycles(3);

    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(d16_valid), 0);
    checkOutput("rst_data", 32'(d16_data), 0);
    checkOutput("rst_index", 32'(d16_index), 0);
    checkOutput("rst_first", 32'(d16_first), 0);
    checkOutput("rst_last", 32'(d16_last), 0);
    checkOutput("rst_done", 32'(d16_done), 0);
    checkOutput("rst_ovr", 32'(d16_ovr), 0);
    checkOutput("rst_ovr_cnt", 32'(d1_ovr_cnt), 0);
    reset_n = 1'b1;

    $display("[TB] basic frame");
    applyStimulus(15);
    checkOutput("basic_no_early", 32'(d16_valid), 0);
    clk_sampling = 1'b1;
    step_cycles(2);
    checkOutput("basic_lat_e2", 32'(d16_valid), 0);
    step_cycles(1);
    checkOutput("basic_lat_e3", 32'(d16_valid), 1);
    clk_sampling = 1'b0;
    for (int b = 0; b < 16; b++) begin
      checkOutput("basic_data", 32'(d16_data), 32'((15 - b) * 64));
      checkOutput("basic_index", 32'(d16_index), 32'(b));
      checkOutput("basic_first", 32'(d16_first), (b == 0) ? 1 : 0);
      checkOutput("basic_last", 32'(d16_last), (b == 15) ? 1 : 0);
      checkOutput("basic_no_done", 32'(d16_done), 0);
      step_cycles(1);
    end
    checkOutput("basic_done", 32'(d16_done), 1);
    checkOutput("basic_idle", 32'(d16_valid), 0);
    step_cycles(1);
    checkOutput("basic_done_pulse", 32'(d16_done), 0);

    $display("[TB] backpressure");
    applyStimulus(15);
    clk_sampling = 1'b1;
    step_cycles(3);
    clk_sampling = 1'b0;
    for (int b = 0; b < 16; b++) begin
      checkOutput("bp_data", 32'(d16_data), 32'((15 - b) * 64));
      checkOutput("bp_index", 32'(d16_index), 32'(b));
      if (b == 7) begin
        d16_ready = 1'b0;
        for (int i = 0; i < 16; i++) samples[i] = 18'h2AAAA;
        repeat (5) begin
          step_cycles(1);
          checkOutput("bp_hold_data", 32'(d16_data), 512);
          checkOutput("bp_hold_index", 32'(d16_index), 7);
          checkOutput("bp_hold_valid", 32'(d16_valid), 1);
        end
        d16_ready = 1'b1;
      end
      step_cycles(1);
    end
    checkOutput("bp_done", 32'(d16_done), 1);
    load_ramp();

    $display("[TB] overrun");
    reset_n      = 1'b0;
    clk_sampling = 1'b1;
    d1_ready     = 1'b0;
    step_cycles(2);
    checkOutput("ovr_rst_valid", 32'(d1_valid), 0);
    checkOutput("ovr_rst_first", 32'(d1_first), 0);
    reset_n = 1'b1;
    step_cycles(2);
    checkOutput("hi_rst_e2", 32'(d1_valid), 0);
    step_cycles(1);
    checkOutput("hi_rst_e3", 32'(d1_valid), 1);
    checkOutput("hi_rst_data", 32'(d1_data), 960);
    for (int k = 0; k < 3; k++) begin
      clk_sampling = 1'b0;
      step_cycles(3);
      clk_sampling = 1'b1;
      step_cycles(2);
      checkOutput("ovr_pre", 32'(d1_ovr), 0);
      step_cycles(1);
      checkOutput("ovr_pulse", 32'(d1_ovr), 1);
      step_cycles(1);
      checkOutput("ovr_post", 32'(d1_ovr), 0);
    end
    checkOutput("ovr_cnt3", 32'(d1_ovr_cnt), 3);
    checkOutput("ovr_intact_index", 32'(d1_index), 0);
    checkOutput("ovr_intact_data", 32'(d1_data), 960);
    clk_sampling = 1'b0;
    d1_ready     = 1'b1;
    for (int b = 0; b < 16; b++) begin
      checkOutput("ovr_drain_data", 32'(d1_data), 32'((15 - b) * 64));
      step_cycles(1);
    end
    checkOutput("ovr_drain_done", 32'(d1_done), 1);

    d1_ready     = 1'b0;
    clk_sampling = 1'b1;
    step_cycles(3);
    checkOutput("sat_start", 32'(d1_valid), 1);
    repeat (300) begin
      clk_sampling = 1'b0;
      step_cycles(3);
      clk_sampling = 1'b1;
      step_cycles(3);
    end
    checkOutput("sat_cnt", 32'(d1_ovr_cnt), 255);
    clk_sampling = 1'b0;
    d1_ready     = 1'b1;
    step_cycles(20);

    $display("[TB] back-to-back boundary");
    do_reset();
    clk_sampling = 1'b1;
    step_cycles(3);
    clk_sampling = 1'b0;
    step_cycles(15);
    checkOutput("b2b_at_last", 32'(d1_last), 1);
    d1_ready     = 1'b0;
    clk_sampling = 1'b1;
    step_cycles(2);
    d1_ready = 1'b1;
    step_cycles(1);
    checkOutput("b2b_valid", 32'(d1_valid), 1);
    checkOutput("b2b_index", 32'(d1_index), 0);
    checkOutput("b2b_first", 32'(d1_first), 1);
    checkOutput("b2b_data", 32'(d1_data), 960);
    checkOutput("b2b_done", 32'(d1_done), 1);
    checkOutput("b2b_no_ovr", 32'(d1_ovr), 0);
    clk_sampling = 1'b0;
    step_cycles(16);
    checkOutput("b2b_done2", 32'(d1_done), 1);
    checkOutput("b2b_cnt", 32'(d1_ovr_cnt), 0);

    $display("[TB] reset mid-frame");
    do_reset();
    applyStimulus(15);
    clk_sampling = 1'b1;
    step_cycles(3);
    clk_sampling = 1'b0;
    step_cycles(9);
    checkOutput("mid_index9", 32'(d16_index), 9);
    reset_n = 1'b0;
    step_cycles(1);
    checkOutput("mid_valid", 32'(d16_valid), 0);
    checkOutput("mid_data", 32'(d16_data), 0);
    checkOutput("mid_index", 32'(d16_index), 0);
    checkOutput("mid_first", 32'(d16_first), 0);
    checkOutput("mid_last", 32'(d16_last), 0);
    checkOutput("mid_ovr", 32'(d16_ovr), 0);
    reset_n = 1'b1;
    step_cycles(1);
    checkOutput("mid_no_done", 32'(d16_done), 0);
    applyStimulus(15);
    checkOutput("mid_wait_hop", 32'(d16_valid), 0);
    clk_sampling = 1'b1;
    step_cycles(3);
    checkOutput("mid_restart", 32'(d16_valid), 1);
    checkOutput("mid_restart_idx", 32'(d16_index), 0);
    clk_sampling = 1'b0;
    step_cycles(16);

    $display("[TB] enable gating");
    do_reset();
    applyStimulus(5);
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      checkOutput("en_off", 32'(d16_valid), 0);
    end
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1);
      checkOutput("en_remaining", 32'(d16_valid), 0);
    end
    clk_sampling = 1'b1;
    step_cycles(2);
    checkOutput("en_e2", 32'(d16_valid), 0);
    step_cycles(1);
    checkOutput("en_start", 32'(d16_valid), 1);
    clk_sampling = 1'b0;
    step_cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mic_window_reader.md
# mic_window_reader

Consumer side of the microphone sample window. Detects each rising edge of the divided sampling clock, snapshots the 16-entry, 18-bit sample window on the selected edges, and streams the snapshot oldest-first to the downstream FFT/visualizer over a valid/ready interface. Runs entirely in the 25 MHz domain. Flags windows dropped because the previous frame is still streaming.

## Interface
Parameters:
- DEPTH, 16, window length in samples; matches the sampler's shift-register depth.
- WIDTH, 18, sample width in bits.
- HOP, 16, sampling-clock edges per snapshot. Legal range 1..256. 16 gives non-overlapping windows.

Ports:
- clk_25  in  1  25 MHz system clock. Only clock.
- reset_n  in  1  Synchronous, active-low reset.
- clk_sampling  in  1  Divided sampling clock from the sampler; treated as a level and edge-detected.
- samples  in  WIDTH x [0:DEPTH-1]  Sample window. Index 0 is newest; DEPTH-1 is oldest.
- enable  in  1  When low, no new snapshots start and hop_cnt holds. A frame in flight completes.
- out_data  out  WIDTH  Current sample beat.
- out_index  out  $clog2(DEPTH)  Beat number, 0..DEPTH-1.
- out_first  out  1  High on beat 0.
- out_last  out  1  High on beat DEPTH-1.
- out_valid  out  1  Beat valid.
- out_ready  in  1  Downstream accepts the beat.
- frame_done  out  1  One-cycle pulse after the last beat is accepted.
- overrun  out  1  One-cycle pulse when a due snapshot is dropped.
- overrun_count  out  8  Saturating count of dropped windows.

## Operation
- **Edge detect:** clk_sampling passes through registers s1 → s2 → s3. tick = s2 & ~s3.
- **Hop counter:** hop_cnt counts ticks while enable is high and wraps from HOP-1 to 0. due = tick & enable & (hop_cnt == HOP-1).
- **States:**
  - IDLE → STREAM on due. The snapshot register captures all of samples, idx = 0.
  - STREAM → IDLE when the last beat handshakes (out_valid & out_ready & idx == DEPTH-1) and due is low. frame_done pulses.
  - STREAM → STREAM on last handshake with due high. New snapshot, idx = 0, frame_done pulses, no overrun, no idle gap.
  - STREAM on due without a last handshake: window dropped, overrun pulses, overrun_count += 1 (saturates at 255). The current frame is unaffected.
- **Beat data:**
  - out_data = snap[DEPTH-1-idx], so the oldest sample goes first.
  - out_index = idx; out_first = (idx == 0); out_last = (idx == DEPTH-1).
  - out_valid = (state == STREAM).
- **Handshake:** a beat transfers on a clock edge with out_valid & out_ready high; idx then increments.
  - While out_ready is low, out_data, out_index, out_first and out_last hold stable.
  - out_valid never drops mid-frame.
- The snapshot is isolated from samples: sampler shifts during streaming do not change outgoing data.
- **Reset (reset_n low at a clock edge),** from any state including mid-frame:
  - state = IDLE, idx = 0, hop_cnt = 0, s1/s2/s3 = 0, snapshot = 0, overrun_count = 0.
  - All outputs 0: out_valid, out_data, out_index, out_first, out_last, frame_done, overrun.
  - A partial frame is abandoned; there is no frame_done for it.
- **Clock held high across reset:** after reset s3 = 0, so the first post-reset cycle with s2 high produces a tick.

## Timing
- **clk_sampling rising edge to out_valid:**
  - Let E1 be the first clk_25 edge sampling clk_sampling high. s2 rises at E2, and tick is high between E2 and E3.
  - If due, the snapshot is taken at E3 and out_valid is high after E3. Latency is 3 clk_25 edges.
- The sampler shifts on the same clk_sampling edge. samples must be stable by E3; the sampler's shift completes at the edge, so this holds.
- **Frame length:** DEPTH cycles with out_ready held high (16 cycles). The sampling period is 5000 clk_25 cycles, so overrun needs sustained backpressure.
- frame_done and overrun are single-cycle, registered pulses.
- With HOP = 1, the first snapshot follows the first tick after reset. Otherwise it follows the HOP-th tick.

## Test plan
- **Basic frame.** HOP = 16, ready = 1, samples[i] = i×64, 16 clk_sampling edges.
  - Expect 16 beats, out_data 960, 896, …, 0.
  - out_first on beat 0, out_last on beat 15, frame_done one cycle after beat 15. Latency of 3 edges from E1.
- **Backpressure.** out_ready low for 5 cycles at beat 7.
  - Beat 7 holds (data 512, index 7) and no beat is lost.
  - The frame completes 5 cycles later; samples shifting mid-frame does not alter data.
- **Overrun.** HOP = 1, out_ready held low across 3 ticks.
  - 3 overrun pulses, overrun_count = 3, original frame intact.
  - Saturation: after 300 drops, overrun_count = 255.
- **Back-to-back boundary.** Release ready so the last handshake coincides with due.
  - The next frame's beat 0 follows immediately: out_valid stays high, frame_done pulses, no overrun.
- **Reset mid-frame.** reset_n low at beat 9.
  - Next edge: all outputs 0, state IDLE.
  - The next frame starts only after HOP fresh ticks.
- **Enable gating.** enable low across 20 ticks: no frames, hop_cnt frozen.
  - Raise enable: the frame starts after the remaining ticks of the hop.
